// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, default reset PC and
// the branch/jump opcodes the controller decodes.
package mips_fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory req/ack side plus decode valid/ready side.
// master = fetch unit, slave = memory/decode environment.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pcplus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        pcsrc;
  logic        jump;
  logic [31:0] signimm;

  modport master (
    output imem_req, imem_addr, instr, pcplus4, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, pcsrc, jump, signimm
  );

  modport slave (
    input  imem_req, imem_addr, instr, pcplus4, instr_valid,
    output imem_ack, imem_rdata, instr_ready, pcsrc, jump, signimm
  );
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC mux: sequential, branch-relative or pseudo-direct jump.
module next_pc_sel (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] signimm,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] next_pc,
  output logic [31:0] pcplus4
);

  // Opcode field is decoded by the controller, not needed here.
  logic unused_opcode;
  assign unused_opcode = ^instr[31:26];

  // Jump beats branch; all adds wrap at 32 bits, targets stay word aligned.
  always_comb begin
    pcplus4 = pc + 32'd4;
    if (jump)
      next_pc = {pcplus4[31:28], instr[25:0], 2'b00};
    else if (pcsrc)
      next_pc = pcplus4 + {signimm[29:0], 2'b00};
    else
      next_pc = pcplus4;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word at a time over
// req/ack, holds it for decode over valid/ready, then steps to next_pc.
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  fetch_unit_if.master     bus,
  output logic [CNT_W-1:0] icount
);

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic [31:0]      next_pc;
  logic [31:0]      pcplus4;

  next_pc_sel u_next_pc_sel (
    .pc      (pc_q),
    .instr   (instr_q),
    .signimm (bus.signimm),
    .pcsrc   (bus.pcsrc),
    .jump    (bus.jump),
    .next_pc (next_pc),
    .pcplus4 (pcplus4)
  );

  // FSM: capture on ack in FETCH, advance PC and count on consume in HOLD.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    icount_d = icount_q;
    case (state_q)
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          pc_d     = next_pc;
          icount_d = icount_q + CNT_W'(1);
          state_d  = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State registers; reset abandons any outstanding fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      icount_q <= icount_d;
    end
  end

  // Outputs are straight from state; handshakes are masked during reset.
  always_comb begin
    bus.imem_req    = !reset && (state_q == FETCH);
    bus.instr_valid = !reset && (state_q == HOLD);
    bus.imem_addr   = pc_q;
    bus.instr       = instr_q;
    bus.pcplus4     = pcplus4;
    icount          = icount_q;
  end

endmodule
